// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one i2c_protocol master between NUM_REQ requesters. A round-robin
// grant latches one requester's transaction fields, drives the start/busy/done
// handshake with the master, and returns per-requester ack/done(/err) pulses.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   : a watchdog ends a transaction after TIMEOUT_CYC cycles spent
//               in WAIT_BUSY+WAIT_DONE and pulses req_err instead of req_done.
//   undefined : no watchdog, req_err stays 0, the FSM waits for m_done.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid[N]            per-requester request level
//   req_addr[7N]            7-bit device address, requester i at [7i+6:7i]
//   req_wr_rd[N]            write/read select
//   req_data_st[8N]         first byte (register address)
//   req_data_nd[8N]         second byte (register data)
//   req_ack/done/err[N]     one-cycle pulses: latched / complete / timed out
//   m_start                 one-cycle start to i2c_protocol
//   m_addr/m_wr_rd/m_data_st/m_data_nd  fields latched at grant
//   m_busy, m_done          status from i2c_protocol
//   arb_busy                high whenever the FSM is not IDLE
//   grant_idx               index of the current/last grant
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [7*NUM_REQ-1:0]          req_addr,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [8*NUM_REQ-1:0]          req_data_st,
  input  logic [8*NUM_REQ-1:0]          req_data_nd,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic                          m_start,
  output logic [6:0]                    m_addr,
  output logic                          m_wr_rd,
  output logic [7:0]                    m_data_st,
  output logic [7:0]                    m_data_nd,
  input  logic                          m_busy,
  input  logic                          m_done,
  output logic                          arb_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [IDX_W-1:0]     last_r;
  logic [IDX_W-1:0]     grant_s;
  logic                 grant_hit_s;
  logic                 done_hit_s;
  logic                 err_hit_s;
  logic                 timeout_s;

  logic [NUM_REQ-1:0]   req_ack_r;
  logic [NUM_REQ-1:0]   req_done_r;
  logic [NUM_REQ-1:0]   req_err_r;
  logic                 m_start_r;
  logic [ADDR_W-1:0]    m_addr_r;
  logic                 m_wr_rd_r;
  logic [DATA_W-1:0]    m_data_st_r;
  logic [DATA_W-1:0]    m_data_nd_r;
  logic                 arb_busy_r;
  logic [IDX_W-1:0]     grant_idx_r;

  // Round-robin pick: first set bit searching from last+1 with wrap. The loop
  // walks from the farthest candidate towards the nearest so the nearest wins;
  // offset NUM_REQ is the previous winner itself, which has lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (valid[cand]) begin
        pick = cand;
      end
    end
    return pick;
  endfunction

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog counter: cleared in ISSUE, counts each waiting cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= '0;
    end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The cycle whose edge would make the count reach TIMEOUT_CYC ends the wait.
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode plus the completion events that set the return pulses.
  always_comb begin
    state_s     = state_r;
    grant_s     = rr_pick(req_valid, last_r);
    grant_hit_s = 1'b0;
    done_hit_s  = 1'b0;
    err_hit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_hit_s = 1'b1;
          state_s     = ST_ISSUE;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A done without a visible busy phase still completes the transaction.
        if (m_done) begin
          done_hit_s = 1'b1;
          state_s    = ST_RELEASE;
        end else if (timeout_s) begin
          err_hit_s  = 1'b1;
          state_s    = ST_RELEASE;
        end else if (m_busy) begin
          state_s    = ST_WAIT_DONE;
        end else begin
          state_s    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (m_done) begin
          done_hit_s = 1'b1;
          state_s    = ST_RELEASE;
        end else if (timeout_s) begin
          err_hit_s  = 1'b1;
          state_s    = ST_RELEASE;
        end else begin
          state_s    = ST_WAIT_DONE;
        end
      end
      ST_RELEASE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      last_r      <= IDX_W'(NUM_REQ - 1);
      req_ack_r   <= '0;
      req_done_r  <= '0;
      req_err_r   <= '0;
      m_start_r   <= 1'b0;
      m_addr_r    <= '0;
      m_wr_rd_r   <= 1'b0;
      m_data_st_r <= '0;
      m_data_nd_r <= '0;
      arb_busy_r  <= 1'b0;
      grant_idx_r <= '0;
    end else begin
      state_r    <= state_s;
      req_ack_r  <= '0;
      req_done_r <= '0;
      req_err_r  <= '0;
      // Start is raised in the cycle following the ack.
      m_start_r  <= (state_r == ST_ISSUE);
      arb_busy_r <= (state_s != ST_IDLE);
      if (grant_hit_s) begin
        m_addr_r           <= req_addr[ADDR_W*int'(grant_s) +: ADDR_W];
        m_wr_rd_r          <= req_wr_rd[grant_s];
        m_data_st_r        <= req_data_st[DATA_W*int'(grant_s) +: DATA_W];
        m_data_nd_r        <= req_data_nd[DATA_W*int'(grant_s) +: DATA_W];
        grant_idx_r        <= grant_s;
        last_r             <= grant_s;
        req_ack_r[grant_s] <= 1'b1;
      end
      if (done_hit_s) begin
        req_done_r[grant_idx_r] <= 1'b1;
      end
      if (err_hit_s) begin
        req_err_r[grant_idx_r] <= 1'b1;
      end
    end
  end

  assign req_ack   = req_ack_r;
  assign req_done  = req_done_r;
  assign req_err   = req_err_r;
  assign m_start   = m_start_r;
  assign m_addr    = m_addr_r;
  assign m_wr_rd   = m_wr_rd_r;
  assign m_data_st = m_data_st_r;
  assign m_data_nd = m_data_nd_r;
  assign arb_busy  = arb_busy_r;
  assign grant_idx = grant_idx_r;

endmodule
